// File: rtl/systolic_4_pkg.sv
// Shared constants and types for the 2x2 output-stationary systolic engine.
// Holds the bus address map, data/buffer sizing and the run-control state enum.
package systolic_4_pkg;

    localparam int DATA_W    = 16;
    localparam int BUF_DEPTH = 256;
    localparam int BUF_AW    = 8;

    localparam logic [15:0] SYS_START_ADR = 16'hFFF0;
    localparam logic [15:0] SYS_MAX_CNTR  = 16'hFFF1;
    localparam logic [15:0] SYS_RUN_CNTR  = 16'hFFF2;

    localparam logic [15:0] A0_BASE  = 16'h0000;
    localparam logic [15:0] A1_BASE  = 16'h0100;
    localparam logic [15:0] B0_BASE  = 16'h0200;
    localparam logic [15:0] B1_BASE  = 16'h0300;
    localparam logic [15:0] RES_BASE = 16'h0400;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/systolic_4_iobuf.sv
// Operand buffers: four 256x16 1R1W synchronous RAMs sharing one read address,
// which follows the stream counter while running and the bus address otherwise.
module buf_ab
    import systolic_4_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [BUF_AW-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [BUF_AW-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] ram [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
        rdata <= ram[raddr];
    end

endmodule

module iobuf
    import systolic_4_pkg::*;
(
    input  logic                clk,
    input  logic                run,
    input  logic [BUF_AW-1:0]   cnt,
    input  logic [BUF_AW-1:0]   radr,
    input  logic [3:0]          we,
    input  logic [BUF_AW-1:0]   wadr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q_a0,
    output logic [DATA_W-1:0]   q_a1,
    output logic [DATA_W-1:0]   q_b0,
    output logic [DATA_W-1:0]   q_b1
);

    logic [BUF_AW-1:0] rsel;

    assign rsel = run ? cnt : radr;

    buf_ab a0buf (.clk(clk), .we(we[0]), .waddr(wadr), .wdata(wdata), .raddr(rsel), .rdata(q_a0));
    buf_ab a1buf (.clk(clk), .we(we[1]), .waddr(wadr), .wdata(wdata), .raddr(rsel), .rdata(q_a1));
    buf_ab b0buf (.clk(clk), .we(we[2]), .waddr(wadr), .wdata(wdata), .raddr(rsel), .rdata(q_b0));
    buf_ab b1buf (.clk(clk), .we(we[3]), .waddr(wadr), .wdata(wdata), .raddr(rsel), .rdata(q_b1));

endmodule

// File: rtl/systolic_4.sv
// 2x2 output-stationary systolic matrix-multiply engine behind a 16-bit register bus.
// Operands stream from local buffers through a skewed PE array into four wrapping accumulators.
module systolic_4
    import systolic_4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic [15:0] ibus_radr,
    output logic [15:0] ibus_rdata,
    input  logic        wen,
    input  logic [15:0] ibus_wadr,
    input  logic [15:0] ibus_wdata
);

    state_t      state;
    logic        busy;
    logic        done;
    logic [8:0]  cnt;
    logic [7:0]  max_cntr;
    logic [7:0]  run_cntr;

    logic        run;
    logic        last;
    logic        start_req;
    logic [3:0]  buf_we;

    logic [15:0] q_a0, q_a1, q_b0, q_b1;
    logic        feed_v;
    logic [15:0] a0_d, b0_d, a1_d, b1_d;
    logic        v_d;
    logic [15:0] a1_dd, b1_dd;
    logic        v_dd;

    logic [15:0] pe_a [4];
    logic [15:0] pe_b [4];
    logic        pe_v [4];
    logic [15:0] prod [4];
    logic [15:0] acc  [4];

    logic        rd_fresh;
    logic        rd_is_buf;
    logic [1:0]  rd_sel;
    logic [15:0] rd_reg;
    logic [15:0] rd_hold;
    logic [15:0] reg_mux;
    logic [15:0] buf_mux;

    assign run       = (state == ST_RUN);
    assign last      = (cnt == ({1'b0, max_cntr} + {1'b0, run_cntr}));
    assign start_req = wen && (ibus_wadr == SYS_START_ADR) && ibus_wdata[0] && (state == ST_IDLE);
    assign buf_we    = (wen && (ibus_wadr[15:10] == 6'd0)) ? (4'b0001 << ibus_wadr[9:8]) : 4'b0000;

    iobuf u_iobuf (
        .clk   (clk),
        .run   (run),
        .cnt   (cnt[7:0]),
        .radr  (ibus_radr[7:0]),
        .we    (buf_we),
        .wadr  (ibus_wadr[7:0]),
        .wdata (ibus_wdata),
        .q_a0  (q_a0),
        .q_a1  (q_a1),
        .q_b0  (q_b0),
        .q_b1  (q_b1)
    );

    // A start write landing on the completing edge sees RUN and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_cntr <= '0;
            run_cntr <= '0;
        end else if (wen && !busy) begin
            if (ibus_wadr == SYS_MAX_CNTR) max_cntr <= ibus_wdata[7:0];
            if (ibus_wadr == SYS_RUN_CNTR) run_cntr <= ibus_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feed_v <= 1'b0;
            v_d    <= 1'b0;
            v_dd   <= 1'b0;
        end else begin
            feed_v <= run && (cnt <= {1'b0, max_cntr});
            v_d    <= feed_v;
            v_dd   <= v_d;
        end
    end

    // One register between neighbouring PEs; A1/B1 take one extra skew stage.
    always_ff @(posedge clk) begin
        a0_d  <= q_a0;
        b0_d  <= q_b0;
        a1_d  <= q_a1;
        b1_d  <= q_b1;
        a1_dd <= a1_d;
        b1_dd <= b1_d;
    end

    always_comb begin
        pe_a[0] = q_a0;  pe_b[0] = q_b0;  pe_v[0] = feed_v;
        pe_a[1] = a0_d;  pe_b[1] = b1_d;  pe_v[1] = v_d;
        pe_a[2] = a1_d;  pe_b[2] = b0_d;  pe_v[2] = v_d;
        pe_a[3] = a1_dd; pe_b[3] = b1_dd; pe_v[3] = v_dd;
        for (int i = 0; i < 4; i++) begin
            prod[i] = pe_a[i] * pe_b[i];
        end
    end

    // MACs outside RUN are discarded so a short drain leaves partial sums.
    always_ff @(posedge clk) begin
        if (rst || start_req) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (run && pe_v[i]) acc[i] <= acc[i] + prod[i];
            end
        end
    end

    always_comb begin
        reg_mux = '0;
        if (ibus_radr == SYS_START_ADR) begin
            reg_mux = {14'b0, done, busy};
        end else if (ibus_radr == SYS_MAX_CNTR) begin
            reg_mux = {8'b0, max_cntr};
        end else if (ibus_radr == SYS_RUN_CNTR) begin
            reg_mux = {8'b0, run_cntr};
        end else if (ibus_radr[15:2] == RES_BASE[15:2]) begin
            reg_mux = acc[ibus_radr[1:0]];
        end
    end

    always_comb begin
        case (rd_sel)
            2'd0:    buf_mux = q_a0;
            2'd1:    buf_mux = q_a1;
            2'd2:    buf_mux = q_b0;
            default: buf_mux = q_b1;
        endcase
    end

    // Buffer reads come straight off the RAM output register; rd_hold keeps the bus stable otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_fresh  <= 1'b0;
            rd_is_buf <= 1'b0;
            rd_sel    <= '0;
            rd_reg    <= '0;
            rd_hold   <= '0;
        end else begin
            rd_hold  <= ibus_rdata;
            rd_fresh <= ren;
            if (ren) begin
                rd_is_buf <= (ibus_radr[15:10] == 6'd0);
                rd_sel    <= ibus_radr[9:8];
                rd_reg    <= reg_mux;
            end
        end
    end

    assign ibus_rdata = !rd_fresh ? rd_hold : (rd_is_buf ? buf_mux : rd_reg);

endmodule

// File: tb/tb_systolic_4.sv
// Scoreboard bench for systolic_4: bus reads push expected words, a monitor pops them
// on the cycle after the read strobe and compares against the DUT read data.
module tb_systolic_4;

    logic        clk;
    logic        rst;
    logic        ren;
    logic [15:0] ibus_radr;
    logic [15:0] ibus_rdata;
    logic        wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus_wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    string       tag_q [$];

    logic [15:0] m_a0 [256];
    logic [15:0] m_a1 [256];
    logic [15:0] m_b0 [256];
    logic [15:0] m_b1 [256];

    systolic_4 dut (
        .clk        (clk),
        .rst        (rst),
        .ren        (ren),
        .ibus_radr  (ibus_radr),
        .ibus_rdata (ibus_rdata),
        .wen        (wen),
        .ibus_wadr  (ibus_wadr),
        .ibus_wdata (ibus_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ren) begin
            #1;
            if (exp_q.size() == 0) begin
                check_output("queue_underflow", exp_q.size(), 1);
            end else begin
                check_output(tag_q.pop_front(), {16'h0, ibus_rdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // Every task starts and ends aligned to a falling edge.
    task automatic bus_write(input logic [15:0] adr, input logic [15:0] data);
        wen = 1'b1; ibus_wadr = adr; ibus_wdata = data;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] adr, input logic [15:0] exp, input string tag);
        ren = 1'b1; ibus_radr = adr;
        exp_q.push_back(exp); tag_q.push_back(tag);
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic load_buf(input int which, input int idx, input logic [15:0] v);
        logic [15:0] adr;
        adr = 16'(which * 256 + idx);
        bus_write(adr, v);
        case (which)
            0: m_a0[idx] = v;
            1: m_a1[idx] = v;
            2: m_b0[idx] = v;
            default: m_b1[idx] = v;
        endcase
    endtask

    function automatic logic [15:0] model_c(input int r, input int c, input int mx);
        logic [15:0] s, a, b;
        s = 16'h0;
        for (int k = 0; k <= mx; k++) begin
            a = (r == 0) ? m_a0[k] : m_a1[k];
            b = (c == 0) ? m_b0[k] : m_b1[k];
            s = s + a * b;
        end
        return s;
    endfunction

    task automatic poll_status(input int ones, input int twos);
        for (int i = 0; i < ones + twos; i++) begin
            ren = 1'b1; ibus_radr = 16'hFFF0;
            exp_q.push_back((i < ones) ? 16'h0001 : 16'h0002);
            tag_q.push_back("status");
            @(negedge clk);
        end
        ren = 1'b0;
    endtask

    task automatic check_results(input int mx, input string tag);
        bus_read(16'h0400, model_c(0, 0, mx), {tag, "_c00"});
        bus_read(16'h0401, model_c(0, 1, mx), {tag, "_c01"});
        bus_read(16'h0402, model_c(1, 0, mx), {tag, "_c10"});
        bus_read(16'h0403, model_c(1, 1, mx), {tag, "_c11"});
    endtask

    task automatic apply_stimulus();
        for (int k = 0; k < 4; k++) begin
            load_buf(0, k, 16'(k + 1));
            load_buf(1, k, 16'(k + 5));
            load_buf(2, k, 16'h0001);
            load_buf(3, k, 16'(k + 1));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0;
        ibus_radr = '0; ibus_wadr = '0; ibus_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_output("rdata_reset", {16'h0, ibus_rdata}, 32'h0);
        bus_read(16'hFFF0, 16'h0, "reset_status");
        bus_read(16'hFFF1, 16'h0, "reset_max");
        bus_read(16'hFFF2, 16'h0, "reset_run");
        bus_read(16'h0400, 16'h0, "reset_c00");
        bus_read(16'h0401, 16'h0, "reset_c01");
        bus_read(16'h0402, 16'h0, "reset_c10");
        bus_read(16'h0403, 16'h0, "reset_c11");

        apply_stimulus();
        bus_write(16'hFFF1, 16'h0003);
        bus_write(16'hFFF2, 16'h0003);
        bus_write(16'hFFF0, 16'hFFFF);
        poll_status(7, 2);
        check_results(3, "run1");
        bus_read(16'h0400, 16'd10, "run1_c00_const");
        bus_read(16'h0403, 16'd70, "run1_c11_const");

        bus_write(16'h0400, 16'h1234);
        bus_read(16'h0400, model_c(0, 0, 3), "result_write_ignored");
        bus_read(16'h0500, 16'h0, "unmapped_read");

        load_buf(1, 5, 16'hBEEF);
        bus_read(16'h0105, 16'hBEEF, "buf_readback");
        repeat (2) @(negedge clk);
        check_output("rdata_hold", {16'h0, ibus_rdata}, 32'hBEEF);

        load_buf(1, 6, 16'h1111);
        wen = 1'b1; ibus_wadr = 16'h0106; ibus_wdata = 16'h2222;
        ren = 1'b1; ibus_radr = 16'h0106;
        exp_q.push_back(16'h1111); tag_q.push_back("rw_same_cycle_old");
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        m_a1[6] = 16'h2222;
        bus_read(16'h0106, 16'h2222, "rw_same_cycle_new");

        bus_write(16'hFFF0, 16'h0001);
        bus_write(16'hFFF1, 16'h0000);
        bus_write(16'hFFF0, 16'h0001);
        poll_status(5, 2);
        check_results(3, "busy_ignore");
        bus_read(16'hFFF1, 16'h0003, "max_write_ignored");

        load_buf(0, 0, 16'hFFFF);
        load_buf(2, 0, 16'hFFFF);
        bus_write(16'hFFF1, 16'h0000);
        bus_write(16'hFFF0, 16'h0001);
        poll_status(4, 2);
        check_results(0, "wrap");
        bus_read(16'h0400, 16'h0001, "wrap_c00_const");

        bus_write(16'hFFF1, 16'h0003);
        bus_write(16'hFFF0, 16'h0001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_read(16'hFFF0, 16'h0, "abort_status");
        bus_read(16'hFFF1, 16'h0, "abort_max");
        bus_read(16'hFFF2, 16'h0, "abort_run");
        bus_read(16'h0400, 16'h0, "abort_c00");
        bus_read(16'h0401, 16'h0, "abort_c01");
        bus_read(16'h0402, 16'h0, "abort_c10");
        bus_read(16'h0403, 16'h0, "abort_c11");

        bus_write(16'hFFF1, 16'h0003);
        bus_write(16'hFFF2, 16'h0003);
        bus_write(16'hFFF0, 16'h0001);
        poll_status(7, 2);
        check_results(3, "restart");

        repeat (2) @(negedge clk);
        check_output("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
